// File: rtl/scarv_axi_responder_pkg.sv
// Shared encodings and channel widths for the AXI4-lite SRAM responder.
package scarv_axi_responder_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam int AXI_PROT_W = 3;

    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK_DEFAULT = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WR_MEM     = 3'd2,
        ST_WR_RESP    = 3'd3,
        ST_RD_MEM     = 3'd4,
        ST_RD_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/scarv_axi_sram_responder.sv
// AXI4-lite slave serialising one master's reads and writes onto a
// single-port enable/stall SRAM, with round-robin arbitration and sticky error.
module scarv_axi_sram_responder
    import scarv_axi_responder_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] ADDR_MASK = ADDR_MASK_DEFAULT
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,

    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [AXI_ADDR_W-1:0] axi_awaddr,
    input  logic [AXI_PROT_W-1:0] axi_awprot,

    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [AXI_DATA_W-1:0] axi_wdata,
    input  logic [AXI_STRB_W-1:0] axi_wstrb,

    output logic                  axi_bvalid,
    input  logic                  axi_bready,

    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [AXI_ADDR_W-1:0] axi_araddr,
    input  logic [AXI_PROT_W-1:0] axi_arprot,

    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [AXI_DATA_W-1:0] axi_rdata,

    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [AXI_ADDR_W-1:0] mem_addr,
    output logic [AXI_DATA_W-1:0] mem_wdata,
    output logic [AXI_STRB_W-1:0] mem_ben,
    input  logic [AXI_DATA_W-1:0] mem_rdata,
    input  logic                  mem_stall,
    input  logic                  mem_error,

    output logic                  bus_error
);

    // The memory is word-addressed regardless of the mask the integrator picks.
    localparam logic [AXI_ADDR_W-1:0] EFF_MASK = ADDR_MASK & 32'hFFFF_FFFC;

    state_t                r_state;
    logic                  r_last_rd;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [AXI_ADDR_W-1:0] r_aw_addr;
    logic [AXI_DATA_W-1:0] r_w_data;
    logic [AXI_STRB_W-1:0] r_w_strb;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [AXI_DATA_W-1:0] r_rdata;
    logic                  r_mem_cen;
    logic                  r_mem_wen;
    logic [AXI_ADDR_W-1:0] r_mem_addr;
    logic [AXI_DATA_W-1:0] r_mem_wdata;
    logic [AXI_STRB_W-1:0] r_mem_ben;
    logic                  r_bus_error;

    logic                  w_idle;
    logic                  w_wr_grant;
    logic                  w_rd_grant;
    logic                  w_awready;
    logic                  w_wready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_commit;
    logic                  w_mem_accept;
    logic [AXI_ADDR_W-1:0] w_wr_addr;
    logic [AXI_DATA_W-1:0] w_wr_data;
    logic [AXI_STRB_W-1:0] w_wr_strb;
    logic                  w_unused;

    assign w_unused   = ^{axi_awprot, axi_arprot};

    assign w_idle     = (r_state == ST_IDLE);
    assign w_wr_grant = w_idle && (axi_awvalid || axi_wvalid) && (!axi_arvalid || r_last_rd);
    assign w_rd_grant = w_idle && axi_arvalid && !w_wr_grant;

    // NOTE: every output of a combinational block gets a default first, so no
    // state leaves a ready undriven and no latch is inferred.
    always_comb begin
        w_awready = 1'b0;
        w_wready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_awready = w_wr_grant;
                w_wready  = w_wr_grant;
            end
            ST_WR_COLLECT: begin
                w_awready = !r_aw_got;
                w_wready  = !r_w_got;
            end
            default: ;
        endcase
    end

    assign w_aw_hs      = axi_awvalid && w_awready;
    assign w_w_hs       = axi_wvalid && w_wready;
    assign w_wr_commit  = (w_wr_grant || (r_state == ST_WR_COLLECT)) &&
                          (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
    assign w_mem_accept = r_mem_cen && !mem_stall;

    // A channel handshaken in the committing cycle bypasses its holding register.
    assign w_wr_addr = w_aw_hs ? axi_awaddr : r_aw_addr;
    assign w_wr_data = w_w_hs  ? axi_wdata  : r_w_data;
    assign w_wr_strb = w_w_hs  ? axi_wstrb  : r_w_strb;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state     <= ST_IDLE;
            r_last_rd   <= 1'b0;
            r_aw_got    <= 1'b0;
            r_w_got     <= 1'b0;
            r_aw_addr   <= '0;
            r_w_data    <= '0;
            r_w_strb    <= '0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_mem_cen   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_ben   <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_mem_accept && mem_error) begin
                r_bus_error <= 1'b1;
            end

            if (w_aw_hs) begin
                r_aw_got  <= 1'b1;
                r_aw_addr <= axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_got  <= 1'b1;
                r_w_data <= axi_wdata;
                r_w_strb <= axi_wstrb;
            end

            if (w_wr_commit) begin
                r_mem_cen   <= 1'b1;
                r_mem_wen   <= 1'b1;
                r_mem_addr  <= w_wr_addr & EFF_MASK;
                r_mem_wdata <= w_wr_data;
                r_mem_ben   <= w_wr_strb;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_grant) begin
                        r_last_rd <= 1'b0;
                        r_state   <= w_wr_commit ? ST_WR_MEM : ST_WR_COLLECT;
                    end else if (w_rd_grant) begin
                        r_last_rd  <= 1'b1;
                        r_mem_cen  <= 1'b1;
                        r_mem_wen  <= 1'b0;
                        r_mem_ben  <= '0;
                        r_mem_addr <= axi_araddr & EFF_MASK;
                        r_state    <= ST_RD_MEM;
                    end
                end
                ST_WR_COLLECT: begin
                    if (w_wr_commit) begin
                        r_state <= ST_WR_MEM;
                    end
                end
                ST_WR_MEM: begin
                    if (!mem_stall) begin
                        r_mem_cen <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_MEM: begin
                    if (!mem_stall) begin
                        r_rdata   <= mem_rdata;
                        r_mem_cen <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign axi_awready = w_awready;
    assign axi_wready  = w_wready;
    assign axi_arready = w_rd_grant;
    assign axi_bvalid  = r_bvalid;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign mem_cen     = r_mem_cen;
    assign mem_wen     = r_mem_wen;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_ben     = r_mem_ben;
    assign bus_error   = r_bus_error;

endmodule
